// File: rtl/multiplier_pkg.sv
// Shared constants and state/strobe types for the D1 shift-add multiplier.
// The controller, iteration counter and datapath all import this package.
package multiplier_pkg;

  localparam int ITERATIONS = 4;
  localparam int COUNT_W    = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    TEST = 3'd2,
    ADDS = 3'd3,
    SHFT = 3'd4,
    FIN  = 3'd5
  } mult_state_t;

  // One bit per controller output, in port order.
  typedef struct packed {
    logic ready;
    logic reset;
    logic decrement;
    logic load;
    logic add;
    logic shift;
    logic done;
  } ctrl_t;

endpackage

// File: rtl/mult_controller.sv
// Moore control FSM sequencing one 4-bit shift-add multiply: 11+k cycles from START to READY.
// No backpressure: START is taken only in IDLE, and START in any other state is dropped.
module mult_controller #(
  parameter int COUNT_W = multiplier_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               START,
  input  logic               Q0,
  input  logic [COUNT_W-1:0] count,
  output logic               RESET,
  output logic               DECREMENT,
  output logic               LOAD,
  output logic               ADD,
  output logic               SHIFT,
  output logic               READY,
  output logic               DONE
);
  import multiplier_pkg::*;

  mult_state_t state;
  mult_state_t state_nxt;
  ctrl_t       ctrl;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // count is read in TEST, one edge after SHFT has applied DECREMENT.
  always_comb begin
    state_nxt = IDLE;
    ctrl      = '0;
    case (state)
      IDLE: begin
        ctrl.ready = 1'b1;
        state_nxt  = START ? INIT : IDLE;
      end
      INIT: begin
        ctrl.reset = 1'b1;
        ctrl.load  = 1'b1;
        state_nxt  = TEST;
      end
      TEST: begin
        if (count == '0) begin
          state_nxt = FIN;
        end else if (Q0) begin
          state_nxt = ADDS;
        end else begin
          state_nxt = SHFT;
        end
      end
      ADDS: begin
        ctrl.add  = 1'b1;
        state_nxt = SHFT;
      end
      SHFT: begin
        ctrl.shift     = 1'b1;
        ctrl.decrement = 1'b1;
        state_nxt      = TEST;
      end
      FIN: begin
        ctrl.done = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign READY     = ctrl.ready;
  assign RESET     = ctrl.reset;
  assign DECREMENT = ctrl.decrement;
  assign LOAD      = ctrl.load;
  assign ADD       = ctrl.add;
  assign SHIFT     = ctrl.shift;
  assign DONE      = ctrl.done;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller with a behavioural counter and shift-add datapath around it.
// Expected DONE events are queued at START and checked by an independent monitor.
module tb_mult_controller;
  import multiplier_pkg::*;

  typedef struct {
    int done_cyc;
    int product;
    int adds;
    int decs;
  } exp_t;

  logic               clk = 1'b0;
  logic               n_reset = 1'b0;
  logic               START = 1'b0;
  logic               Q0;
  logic [COUNT_W-1:0] count = '0;
  logic               RESET, DECREMENT, LOAD, ADD, SHIFT, READY, DONE;

  logic [3:0] a_op = 4'd0;
  logic [3:0] b_op = 4'd0;
  logic [3:0] m_reg = 4'd0;
  logic [3:0] acc = 4'd0;
  logic [3:0] q_reg = 4'd0;
  logic       carry = 1'b0;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   add_cnt = 0;
  int   dec_cnt = 0;
  bit   prev_add = 1'b0;
  exp_t sb[$];

  mult_controller #(.COUNT_W(COUNT_W)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .START    (START),
    .Q0       (Q0),
    .count    (count),
    .RESET    (RESET),
    .DECREMENT(DECREMENT),
    .LOAD     (LOAD),
    .ADD      (ADD),
    .SHIFT    (SHIFT),
    .READY    (READY),
    .DONE     (DONE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Iteration counter as the parent would instantiate it.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) count <= '0;
    else if (RESET) count <= COUNT_W'(ITERATIONS);
    else if (DECREMENT) count <= count - 1'b1;
  end

  // Shift-add datapath: {carry, acc, q_reg} with the product in {acc, q_reg}.
  always @(posedge clk) begin
    if (LOAD) begin
      carry <= 1'b0;
      acc   <= 4'd0;
      q_reg <= b_op;
      m_reg <= a_op;
    end else if (ADD) begin
      {carry, acc} <= {1'b0, acc} + {1'b0, m_reg};
    end else if (SHIFT) begin
      {carry, acc, q_reg} <= {1'b0, carry, acc, q_reg[3:1]};
    end
  end
  assign Q0 = q_reg[0];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on every DONE and checks strobe discipline.
  always @(negedge clk) begin
    if (prev_add) chk("add_then_shift", int'(SHIFT), 1);
    if (DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("product", int'({acc, q_reg}), e.product);
        chk("add_pulses", add_cnt, e.adds);
        chk("dec_pulses", dec_cnt, e.decs);
      end
    end
    if (LOAD) begin
      add_cnt = 0;
      dec_cnt = 0;
    end
    if (ADD) add_cnt++;
    if (DECREMENT) dec_cnt++;
    prev_add = ADD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int k,
                        input int prod, input bit poke);
    int   e0;
    exp_t e;
    chk("ready_before_start", int'(READY), 1);
    a_op = a;
    b_op = b;
    e0 = cyc + 1;
    e.done_cyc = e0 + 10 + k;
    e.product  = prod;
    e.adds     = k;
    e.decs     = ITERATIONS;
    sb.push_back(e);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("load_in_init", int'(LOAD), 1);
    chk("reset_in_init", int'(RESET), 1);
    while (cyc < e0 + 10 + k) begin
      tick();
      if (poke) START = ADD | SHIFT;
    end
    START = 1'b0;
    chk("busy_in_fin", int'(READY), 0);
    tick();
    chk("ready_after_fin", int'(READY), 1);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || !READY) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    // Reset held with the clock running.
    repeat (3) tick();
    chk("rst_ready", int'(READY), 1);
    chk("rst_reset", int'(RESET), 0);
    chk("rst_decrement", int'(DECREMENT), 0);
    chk("rst_load", int'(LOAD), 0);
    chk("rst_add", int'(ADD), 0);
    chk("rst_shift", int'(SHIFT), 0);
    chk("rst_done", int'(DONE), 0);
    n_reset = 1'b1;
    repeat (8) tick();
    chk("idle_ready", int'(READY), 1);
    chk("idle_load", int'(LOAD), 0);

    // Multiplier 0000: no ADDs, 11-cycle operation.
    run_op(4'd13, 4'd0, 0, 0, 1'b0);
    repeat (2) tick();
    // Multiplier 1011, multiplicand 1101: 143.
    run_op(4'd13, 4'd11, 3, 143, 1'b0);
    repeat (2) tick();
    // Same operation with START pulsed during every ADDS and SHFT.
    run_op(4'd13, 4'd11, 3, 143, 1'b1);
    repeat (5) tick();
    chk("no_queued_start", int'(READY), 1);

    // Reset dropped during an ADDS cycle abandons the operation.
    a_op = 4'd13;
    b_op = 4'd11;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 20 && !ADD; i++) tick();
    chk("reached_adds", int'(ADD), 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_rst_add", int'(ADD), 0);
    chk("async_rst_ready", int'(READY), 1);
    chk("async_rst_done", int'(DONE), 0);
    repeat (3) tick();
    n_reset = 1'b1;
    repeat (20) tick();
    chk("post_rst_ready", int'(READY), 1);
    // Multiplier 1111, multiplicand 0111: 105, 15-cycle operation.
    run_op(4'd7, 4'd15, 4, 105, 1'b0);
    repeat (2) tick();

    // START held high across two back-to-back operations, multiplier 0001.
    begin
      int   e0;
      exp_t e;
      a_op = 4'd9;
      b_op = 4'd1;
      e0 = cyc + 1;
      e.product = 9;
      e.adds    = 1;
      e.decs    = ITERATIONS;
      e.done_cyc = e0 + 11;
      sb.push_back(e);
      e.done_cyc = e0 + 24;
      sb.push_back(e);
      START = 1'b1;
      while (cyc < e0 + 12) tick();
      chk("held_idle_gap", int'(READY), 1);
      tick();
      chk("held_second_init_ready", int'(READY), 0);
      chk("held_second_init_load", int'(LOAD), 1);
      tick();
      START = 1'b0;
    end
    drain(60);
    repeat (5) tick();
    chk("final_ready", int'(READY), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
